// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Multi-cycle 32-bit signed/unsigned radix-2 restoring divider
//               with valid/ready handshakes on request and result, plus flush.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] div_q,
    output logic [31:0] div_r
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic [31:0] res_q_q, res_q_d;
    logic [31:0] res_r_q, res_r_d;

    logic [32:0] shifted;
    logic [32:0] trial;
    logic        sgn1;
    logic        sgn2;

    assign div_ready = (state_q == IDLE) & ~flush;
    assign out_valid = (state_q == DONE);
    assign div_q     = res_q_q;
    assign div_r     = res_r_q;

    assign shifted = {rem_q, quo_q[31]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign sgn1    = div_signed & div_src1[31];
    assign sgn2    = div_signed & div_src2[31];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        res_q_d = res_q_q;
        res_r_d = res_r_q;

        case (state_q)
            IDLE: begin
                if (div_valid && div_ready) begin
                    s1_d    = sgn1;
                    s2_d    = sgn2;
                    quo_d   = sgn1 ? (32'd0 - div_src1) : div_src1;
                    dvs_d   = sgn2 ? (32'd0 - div_src2) : div_src2;
                    rem_d   = 32'd0;
                    cnt_d   = 5'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    // Sign correction uses this final iteration's values so
                    // the result is registered on the same edge DONE is entered.
                    res_q_d = (s1_q ^ s2_q) ? (32'd0 - quo_d) : quo_d;
                    res_r_d = s1_q ? (32'd0 - rem_d) : rem_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            res_q_q <= 32'd0;
            res_r_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            res_q_q <= res_q_d;
            res_r_q <= res_r_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sequencer
// Description : Directed self-checking bench for div_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

    logic        clk;
    logic        resetn;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] div_q;
    logic [31:0] div_r;

    int tests = 0;
    int fails = 0;

    div_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .div_q      (div_q),
        .div_r      (div_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; it is accepted on that edge.
    task automatic start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        div_signed = sgn;
        div_src1   = a;
        div_src2   = b;
        div_valid  = 1'b1;
        tick();
        div_valid  = 1'b0;
        div_src1   = 32'hDEAD_BEEF;
        div_src2   = 32'h0000_0003;
        div_signed = ~sgn;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int n;
        start(sgn, a, b);
        chk({tag, "_busy_ready"}, {31'd0, div_ready}, 32'd0);
        wait_valid(n);
        chk({tag, "_latency"}, n, 32'd32);
        chk({tag, "_q"}, div_q, eq);
        chk({tag, "_r"}, div_r, er);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_ready"}, {31'd0, div_ready}, 32'd1);
        chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] hq;
        logic [31:0] hr;
        resetn = 1'b0; div_valid = 1'b0; div_signed = 1'b0;
        div_src1 = 32'd0; div_src2 = 32'd0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_q", div_q, 32'd0);
        chk("rst_r", div_r, 32'd0);
        chk("rst_ready", {31'd0, div_ready}, 32'd1);
        resetn = 1'b1;
        tick();

        run_div("u100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2);
        run_div("sn100_7", 1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE);
        run_div("s100_n7", 1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2);
        run_div("s_ovf",   1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0);
        run_div("u_max_1", 1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0);
        run_div("u5_0",    1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5);
        run_div("sn5_0",   1'b1, 32'hFFFFFFFB,  32'd0,         32'd1,         32'hFFFFFFFB);
        run_div("u_big",   1'b0, 32'hFFFFFFFF,  32'h00010000,  32'h0000FFFF,  32'h0000FFFF);

        // Backpressure: result held, a pending request is refused.
        start(1'b0, 32'd50, 32'd6);
        wait_valid(n);
        chk("bp_latency", n, 32'd32);
        hq = div_q;
        hr = div_r;
        chk("bp_q", hq, 32'd8);
        chk("bp_r", hr, 32'd2);
        div_valid = 1'b1; div_signed = 1'b0; div_src1 = 32'd9; div_src2 = 32'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_ready", {31'd0, div_ready}, 32'd0);
            chk("bp_hold_q", div_q, 32'd8);
            chk("bp_hold_r", div_r, 32'd2);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        div_valid = 1'b0;
        chk("bp_after_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_after_ready", {31'd0, div_ready}, 32'd1);
        tick(); tick();
        chk("bp_still_idle", {31'd0, div_ready}, 32'd1);

        // Flush at iteration 10.
        start(1'b0, 32'd1000, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        #1;
        chk("fl_ready_low", {31'd0, div_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_idle_ready", {31'd0, div_ready}, 32'd1);
        chk("fl_idle_valid", {31'd0, out_valid}, 32'd0);
        wait_valid(n);
        chk("fl_never_valid", {31'd0, out_valid}, 32'd0);
        run_div("fl_after", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2);

        // Flush in the same cycle as a request.
        flush = 1'b1; div_valid = 1'b1; div_signed = 1'b0;
        div_src1 = 32'd40; div_src2 = 32'd5;
        #1;
        chk("flv_ready", {31'd0, div_ready}, 32'd0);
        tick();
        flush = 1'b0; div_valid = 1'b0;
        #1;
        chk("flv_not_accepted", {31'd0, div_ready}, 32'd1);
        wait_valid(n);
        chk("flv_no_result", {31'd0, out_valid}, 32'd0);

        // Reset during BUSY.
        start(1'b1, 32'hFFFFFF9C, 32'd7);
        for (int i = 0; i < 5; i++) tick();
        resetn = 1'b0;
        tick();
        chk("rb_valid", {31'd0, out_valid}, 32'd0);
        chk("rb_q", div_q, 32'd0);
        chk("rb_r", div_r, 32'd0);
        chk("rb_ready", {31'd0, div_ready}, 32'd1);
        resetn = 1'b1;
        tick();

        // Reset during DONE.
        start(1'b0, 32'd77, 32'd10);
        wait_valid(n);
        chk("rd_latency", n, 32'd32);
        chk("rd_q_pre", div_q, 32'd7);
        resetn = 1'b0;
        tick();
        chk("rd_valid", {31'd0, out_valid}, 32'd0);
        chk("rd_q", div_q, 32'd0);
        chk("rd_r", div_r, 32'd0);
        chk("rd_ready", {31'd0, div_ready}, 32'd1);
        resetn = 1'b1;
        tick();
        run_div("rd_after", 1'b1, 32'hFFFFFFEC, 32'hFFFFFFFD, 32'd6, 32'hFFFFFFFE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle 32-bit integer divide unit for the EXE stage. It executes DIV.W, MOD.W, DIV.WU and MOD.WU with a radix-2 restoring iteration: one quotient bit per cycle, 32 iterations. The single-cycle ALU cannot host a divide, so EXE issues divides here over a valid/ready handshake and stalls until the result is consumed. It also supports a pipeline flush that cancels a divide in flight.

## Interface
Parameters:
- none; width is fixed at 32 bits.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset. One clock; reset is sampled only on the rising edge of clk.
- div_valid  in  1  EXE presents a divide request.
- div_ready  out  1  unit can accept a request; equals (state==IDLE) & ~flush.
- div_signed  in  1  1 = signed (DIV.W/MOD.W), 0 = unsigned.
- div_src1  in  32  dividend (rj).
- div_src2  in  32  divisor (rk).
- flush  in  1  cancel any divide in flight (exception or ertn in a later stage).
- out_valid  out  1  div_q and div_r hold a valid result.
- out_ready  in  1  EXE/MEM consumes the result.
- div_q  out  32  quotient, sign-corrected.
- div_r  out  32  remainder, sign-corrected.

## Operation
- States:
  - IDLE: wait for a request.
  - BUSY: 32 iterations, 5-bit counter cnt.
  - DONE: hold the result until it is consumed.
- IDLE -> BUSY on div_valid & div_ready. Capture on that edge:
  - sign flags: s1 = div_signed & src1[31], s2 = div_signed & src2[31].
  - magnitudes: |src1| goes into quo, |src2| into dvs. A magnitude is the two's complement when the sign flag is set, otherwise the raw value.
  - rem = 0, cnt = 0.
- BUSY iteration, one per cycle:
  - shifted = {rem[31:0], quo[31]}, 33 bits.
  - trial = shifted - {1'b0, dvs}.
  - If there is no borrow (trial[32]==0): rem <= trial[31:0], quo <= {quo[30:0], 1}.
  - Otherwise: rem <= shifted[31:0], quo <= {quo[30:0], 0}.
  - cnt increments by 1. When the iteration with cnt==31 completes, go to DONE.
- DONE:
  - div_q = (s1^s2) ? -quo : quo.
  - div_r = s1 ? -rem : rem.
  - Sign correction is applied when entering DONE and the result is held in registers, so the outputs are registered.
  - DONE -> IDLE on out_valid & out_ready.
- Divide by zero (no trap in LoongArch):
  - Results follow the algorithm unchanged.
  - Unsigned: q = 0xFFFFFFFF, r = src1.
  - Signed: q = s1 ? 0x00000001 : 0xFFFFFFFF, r = src1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives q = 0x80000000, r = 0.
- flush, in any state, forces IDLE on the next edge and drops any result.
  - flush outranks div_valid: a request in the same cycle is not accepted, because div_ready is 0.
  - flush outranks out_ready: the result is discarded with no handshake.
- resetn low, in any state, forces IDLE on the next edge. Reset values:
  - out_valid = 0.
  - div_q = 0, div_r = 0, cnt = 0, rem = 0, quo = 0.
  - div_ready = 1 once IDLE.

## Timing
- Accept edge E0. Iterations occur on edges E1..E32, and the E32 edge also loads the corrected div_q/div_r and enters DONE.
- out_valid is high in the cycle after E32: 32 cycles after the accept edge, or 33 cycles counting the request cycle.
- out_valid is a registered output: (state==DONE). div_q and div_r are stable for as long as out_valid is high.
- No back-to-back issue. div_ready is low throughout BUSY and DONE, and rises the cycle after the out_valid & out_ready edge. The minimum spacing between accepts is therefore 34 cycles.
- Inputs are sampled only at accept; changes to div_src1/div_src2/div_signed during BUSY have no effect.
- out_ready may be held low indefinitely; DONE persists and the outputs do not change.
- Handshake:
  - Valid may not depend on ready: EXE holds div_valid until it is accepted.
  - out_valid never drops without a consume, except on flush or reset.

## Test plan
- Unsigned basic: src1=100, src2=7, signed=0 -> out_valid 32 cycles after accept; q=14, r=2; div_ready=0 until the consume, then 1.
- Signed mixed signs: src1=0xFFFFFF9C (-100), src2=7, signed=1 -> q=0xFFFFFFF2 (-14), r=0xFFFFFFFE (-2). Also src1=100, src2=-7 -> q=-14, r=2.
- Boundaries:
  - 0x80000000 / 0xFFFFFFFF signed -> q=0x80000000, r=0.
  - 0xFFFFFFFF / 1 unsigned -> q=0xFFFFFFFF, r=0.
  - 5 / 0 unsigned -> q=0xFFFFFFFF, r=5.
  - -5 / 0 signed -> q=1, r=-5.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs constant, div_ready stays 0, and a pending div_valid is not accepted. Release -> one consume, then IDLE.
- Flush:
  - Assert flush at iteration 10 -> IDLE the next cycle, out_valid never rises. A new request then completes correctly (20/3 -> q=6, r=2).
  - flush in the same cycle as div_valid -> not accepted.
- Reset mid-operation: pull resetn low in BUSY and in DONE -> after one edge out_valid=0, div_q=div_r=0, div_ready=1. A following divide is correct.
